// File: rtl/riscv_banked_ram.sv
// Unified instruction/data word RAM with a registered fetch port and a handshaked data port.
// Optional feature macro: RAM_MISALIGN_SPLIT_EN (split misaligned data accesses over two cycles).
module riscv_banked_ram #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_BYTES   = 1024,
  parameter int AW          = $clog2(NUM_BYTES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        i_valid,
  input  logic        d_req,
  output logic        d_ready,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int NUM_WORDS = NUM_BYTES / 4;
  localparam int WI        = AW - 2;

`ifdef RAM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  if (WORD_LENGTH != 32) begin : g_bad_width
    $error("riscv_banked_ram: WORD_LENGTH must be 32");
  end
  if (NUM_BYTES < 8 || (NUM_BYTES & (NUM_BYTES - 1)) != 0) begin : g_bad_size
    $error("riscv_banked_ram: NUM_BYTES must be a power of two >= 8");
  end

  typedef enum logic {IDLE, SPLIT} state_t;

  function automatic logic [31:0] extend(logic [31:0] raw, logic [1:0] size, logic uns);
    case (size)
      2'b00:   return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  logic [31:0]   mem_q [NUM_WORDS];
  state_t        state_q, state_d;
  logic [WI-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d, size_q, size_d;
  logic          we_q, we_d, uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d, lo_q, lo_d;
  logic          i_valid_q, i_valid_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0]   inst_q, inst_d, rdata_q, rdata_d;

  logic [WI-1:0] iw0, iw1, cur_idx, cur_idx1, mem_widx;
  logic [1:0]    cur_lane;
  logic [31:0]   cur_wdata, lo_word, hi_word, rd_pair, mem_wd;
  logic [7:0]    be64;
  logic [63:0]   wd64;
  logic [3:0]    mem_be;
  logic          mem_we, idle, misal, rsv;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^{pc[31:AW], d_addr[31:AW]};

  always_comb begin
    // Fetch: two adjacent words cover any lane offset, so a misaligned pc never stalls.
    iw0       = pc[AW-1:2];
    iw1       = iw0 + WI'(1);
    i_valid_d = i_req;
    inst_d    = i_req ? 32'({mem_q[iw1], mem_q[iw0]} >> {pc[1:0], 3'b000}) : inst_q;

    idle      = (state_q == IDLE);
    cur_idx   = idle ? d_addr[AW-1:2] : idx_q;
    cur_idx1  = cur_idx + WI'(1);
    cur_lane  = idle ? d_addr[1:0] : lane_q;
    cur_wdata = idle ? d_wdata : wdata_q;
    be64      = {4'b0000, size_mask(idle ? d_size : size_q)} << cur_lane;
    wd64      = {32'b0, cur_wdata} << {cur_lane, 3'b000};
    lo_word   = idle ? mem_q[cur_idx] : lo_q;
    hi_word   = mem_q[cur_idx1];
    rd_pair   = 32'({hi_word, lo_word} >> {cur_lane, 3'b000});
    misal     = ((d_size == 2'b01) && d_addr[0]) || ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));
    rsv       = (d_size == 2'b11);

    state_d  = state_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    size_d   = size_q;
    we_d     = we_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    lo_d     = lo_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    mem_we   = 1'b0;
    mem_widx = cur_idx;
    mem_be   = be64[3:0];
    mem_wd   = wd64[31:0];

    case (state_q)
      IDLE: begin
        if (d_req) begin
          if (rsv || (misal && !SPLIT_EN)) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            mem_we = d_we;
            if (misal) begin
              // Lower-word lanes are handled now; the request is parked for the SPLIT edge.
              state_d = SPLIT;
              idx_d   = cur_idx;
              lane_d  = d_addr[1:0];
              size_d  = d_size;
              we_d    = d_we;
              uns_d   = d_unsigned;
              wdata_d = d_wdata;
              lo_d    = lo_word;
            end else begin
              rvalid_d = 1'b1;
              rdata_d  = d_we ? '0 : extend(rd_pair, d_size, d_unsigned);
            end
          end
        end
      end
      SPLIT: begin
        mem_we   = we_q;
        mem_widx = cur_idx1;
        mem_be   = be64[7:4];
        mem_wd   = wd64[63:32];
        rvalid_d = 1'b1;
        rdata_d  = we_q ? '0 : extend(rd_pair, size_q, uns_q);
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < 4; l++) begin
      if (mem_we && mem_be[l]) mem_q[mem_widx][8*l +: 8] <= mem_wd[8*l +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      lo_q      <= '0;
      i_valid_q <= 1'b0;
      inst_q    <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      lo_q      <= lo_d;
      i_valid_q <= i_valid_d;
      inst_q    <= inst_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign d_ready  = (state_q == IDLE);
  assign inst     = inst_q;
  assign i_valid  = i_valid_q;
  assign d_rvalid = rvalid_q;
  assign d_err    = err_q;
  assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_riscv_banked_ram.sv
// Directed + random bench for riscv_banked_ram against a byte-array reference model.
module tb_riscv_banked_ram;
  localparam int N = 1024;

`ifdef RAM_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0, i_valid;
  logic [31:0] pc = '0, inst;
  logic        d_req = 1'b0, d_ready, d_we = 1'b0, d_unsigned = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [1:0]  d_size = '0;
  logic        d_rvalid, d_err;

  int checks = 0, failures = 0;
  logic [7:0] ref_mem [N];

  riscv_banked_ram #(.WORD_LENGTH(32), .NUM_BYTES(N)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .pc(pc), .inst(inst), .i_valid(i_valid),
    .d_req(d_req), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: each byte of the access is handled independently at (addr+k) mod N.
  task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
    int nb, a;
    logic [31:0] v;
    logic misal;
    misal = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    rd = '0; err = 1'b0; lat = 1;
    if (size == 2'd3 || (misal && !SPLIT_EN)) begin
      err = 1'b1;
      return;
    end
    nb = 1 << size;
    v = '0;
    for (int k = 0; k < nb; k++) begin
      a = int'((addr + 32'(k)) % N);
      if (we) ref_mem[a] = wd[8*k +: 8];
      else v[8*k +: 8] = ref_mem[a];
    end
    if (!we) begin
      if (nb == 1) v = uns ? (v & 32'hFF) : 32'($signed(v[7:0]));
      else if (nb == 2) v = uns ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
      rd = v;
    end
    lat = misal ? 2 : 1;
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[int'((a + 32'(k)) % N)];
    return w;
  endfunction

  task automatic data_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input string tag,
                         output logic [31:0] obs);
    logic [31:0] exp_rd;
    logic exp_err;
    int exp_lat, n, guard;
    model(we, addr, size, uns, wd, exp_rd, exp_err, exp_lat);
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wd;
    guard = 0;
    while (!d_ready && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    n = 1;
    if (exp_lat == 2) check({31'b0, d_ready}, 32'd0, {tag, "_ready_low"});
    while (!d_rvalid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    check(32'(n), 32'(exp_lat), {tag, "_latency"});
    check({31'b0, d_err}, {31'b0, exp_err}, {tag, "_err"});
    check(d_rdata, exp_rd, {tag, "_rdata"});
    obs = d_rdata;
  endtask

  task automatic fetch(input logic [31:0] a, input string tag, output logic [31:0] obs);
    logic [31:0] exp;
    exp = model_fetch(a);
    i_req = 1'b1; pc = a;
    @(posedge clk); #1;
    i_req = 1'b0;
    check({31'b0, i_valid}, 32'd1, {tag, "_ivalid"});
    check(inst, exp, {tag, "_inst"});
    obs = inst;
  endtask

  initial begin
    logic [31:0] r, exp_rd;
    logic e;
    int l;

    #3;
    check({31'b0, d_ready}, 32'd1, "reset_ready");
    check({i_valid, d_rvalid, d_err}, 32'd0, "reset_flags");
    check(inst, 32'd0, "reset_inst");
    check(d_rdata, 32'd0, "reset_rdata");
    #9 rst = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < N / 4; w++) data_op(1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, "init", r);

    // Async reset pulse between edges while a response is on the outputs.
    data_op(1'b0, 32'h8, 2'd2, 1'b0, '0, "pre_rst_load", r);
    fetch(32'h4, "pre_rst_fetch", r);
    #2 rst = 1'b1;
    #1;
    check({i_valid, d_rvalid, d_err, d_ready}, 32'd1, "async_rst_flags");
    check(inst, 32'd0, "async_rst_inst");
    check(d_rdata, 32'd0, "async_rst_rdata");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    data_op(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, "t2_sw", r);
    data_op(1'b0, 32'h10, 2'd2, 1'b0, '0, "t2_lw", r);
    check(r, 32'hDEADBEEF, "t2_lw_const");

    data_op(1'b1, 32'h11, 2'd0, 1'b0, 32'h80, "t3_sb", r);
    data_op(1'b0, 32'h11, 2'd0, 1'b0, '0, "t3_lb", r);
    check(r, 32'hFFFFFF80, "t3_lb_const");
    data_op(1'b0, 32'h11, 2'd0, 1'b1, '0, "t3_lbu", r);
    check(r, 32'h00000080, "t3_lbu_const");
    data_op(1'b0, 32'h10, 2'd2, 1'b0, '0, "t3_lw", r);
    check(r, 32'hDEAD80EF, "t3_lw_const");

    data_op(1'b1, 32'h0E, 2'd2, 1'b0, 32'h11223344, "t4_sw_mis", r);
    data_op(1'b0, 32'h0E, 2'd1, 1'b1, '0, "t4_lhu_0e", r);
    data_op(1'b0, 32'h10, 2'd1, 1'b1, '0, "t4_lhu_10", r);
    if (SPLIT_EN) check(r, 32'h1122, "t4_lhu_10_const");
    else check(r, 32'h80EF, "t4_unchanged_const");

    data_op(1'b1, 32'h3FF, 2'd1, 1'b0, 32'hABCD, "t5_sh_wrap", r);
    data_op(1'b0, 32'h3FF, 2'd0, 1'b1, '0, "t5_lbu_3ff", r);
    data_op(1'b0, 32'h0, 2'd0, 1'b1, '0, "t5_lbu_000", r);
    fetch(32'h3FF, "t5_fetch_wrap", r);
    fetch(32'hFFFF_F3FF, "t5_fetch_hi_bits", r);

    data_op(1'b1, 32'h20, 2'd2, 1'b0, 32'h13, "t6_sw_old", r);
    i_req = 1'b1; pc = 32'h20;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_size = 2'd2; d_wdata = 32'h5;
    model(1'b1, 32'h20, 2'd2, 1'b0, 32'h5, exp_rd, e, l);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    check(inst, 32'h13, "t6_same_edge_old");
    check({31'b0, d_rvalid}, 32'd1, "t6_store_rvalid");
    fetch(32'h20, "t6_fetch_new", r);
    check(r, 32'h5, "t6_fetch_new_const");
    data_op(1'b1, 32'h20, 2'd3, 1'b0, 32'hFFFFFFFF, "t6_reserved", r);
    data_op(1'b0, 32'h20, 2'd2, 1'b0, '0, "t6_after_rsv", r);
    check(r, 32'h5, "t6_no_write_const");

    if (SPLIT_EN) begin
      // Abort a split store: first-half lanes stay, second half is dropped.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1E; d_size = 2'd2; d_wdata = 32'hA1B2C3D4;
      @(posedge clk); #1;
      d_req = 1'b0;
      rst = 1'b1; #1 rst = 1'b0;
      ref_mem[32'h1E] = 8'hD4; ref_mem[32'h1F] = 8'hC3;
      @(posedge clk); #1;
      check({31'b0, d_rvalid}, 32'd0, "split_abort_no_rvalid");
      data_op(1'b0, 32'h1C, 2'd2, 1'b0, '0, "split_abort_lo", r);
      data_op(1'b0, 32'h20, 2'd2, 1'b0, '0, "split_abort_hi", r);
    end

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 3) == 0)
        fetch($urandom, $sformatf("rnd_fetch%0d", t), r);
      else
        data_op(1'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
                $sformatf("rnd_data%0d", t), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
